// File: rtl/counter_pkg.sv
// Shared definitions for updown_mod_counter: operation codes, direction
// constants and the modulus range check.
package counter_pkg;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_STEP  = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLEAR = 2'd3
    } op_t;

    function automatic bit modulo_ok(input int width, input int modulo);
        return (width >= 1) && (width <= 16) &&
               (modulo >= 2) && (modulo <= (1 << width));
    endfunction

    // Largest count value; collapses to 0 for illegal settings so the
    // elaboration check in the top is the only error reported.
    function automatic int max_count(input int width, input int modulo);
        return modulo_ok(width, modulo) ? (modulo - 1) : 0;
    endfunction

endpackage

// File: rtl/counter_next_state.sv
// Combinational next-count logic for updown_mod_counter.
// Saturating steps when UPDOWN_MOD_COUNTER_SAT_EN is defined, wrapping otherwise.
module counter_next_state
    import counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] I,
    input  op_t              op,
    input  logic             Up,
    output logic [WIDTH-1:0] next_a,
    output logic             term_match
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_count(WIDTH, MODULO));

    logic             at_max;
    logic             at_zero;
    logic             above_max;
    logic [WIDTH-1:0] step_val;

    assign at_max    = (A == MAX);
    assign at_zero   = (A == '0);
    assign above_max = (A > MAX);

    // Never true for an out-of-range A, since both compares are exact.
    assign term_match = (Up == DIR_UP) ? at_max : at_zero;

    always_comb begin
        step_val = A;
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
        if (Up == DIR_UP) begin
            step_val = (at_max || above_max) ? MAX : A + WIDTH'(1);
        end else if (at_zero) begin
            step_val = '0;
        end else begin
            step_val = (above_max && (A - WIDTH'(1) > MAX)) ? MAX : A - WIDTH'(1);
        end
`else
        if (Up == DIR_UP) begin
            step_val = (at_max || above_max) ? '0 : A + WIDTH'(1);
        end else begin
            step_val = (at_zero || above_max) ? MAX : A - WIDTH'(1);
        end
`endif
    end

    always_comb begin
        next_a = A;
        case (op)
            OP_CLEAR: next_a = '0;
            OP_LOAD:  next_a = I;
            OP_STEP:  next_a = step_val;
            default:  next_a = A;
        endcase
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, enable and cascade carry.
// Define UPDOWN_MOD_COUNTER_SAT_EN for saturating instead of wrapping steps.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             Load,
    input  logic             Count,
    input  logic             Up,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] A,
    output logic             C_out,
    output logic             Zero
);

    generate
        if (!modulo_ok(WIDTH, MODULO)) begin : g_bad_param
            $error("updown_mod_counter: WIDTH must be 1..16 and MODULO 2..2**WIDTH");
        end
    endgenerate

    op_t              op;
    logic [WIDTH-1:0] next_a;
    logic             term_match;

    always_comb begin
        if (Clear)      op = OP_CLEAR;
        else if (Load)  op = OP_LOAD;
        else if (Count) op = OP_STEP;
        else            op = OP_HOLD;
    end

    counter_next_state #(
        .WIDTH  (WIDTH),
        .MODULO (MODULO)
    ) u_next (
        .A          (A),
        .I          (I),
        .op         (op),
        .Up         (Up),
        .next_a     (next_a),
        .term_match (term_match)
    );

    // Zero tracks the value being written so it never lags A.
    always_ff @(posedge CLK) begin
        A    <= next_a;
        Zero <= (next_a == '0);
    end

    assign C_out = (op == OP_STEP) && term_match;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: directed vector table plus random stimulus
// checked against an arithmetic model, on MODULO=10 and MODULO=16 instances.
module tb_updown_mod_counter;

    logic       CLK = 1'b0;
    logic       Clear = 1'b0;
    logic       Load = 1'b0;
    logic       Count = 1'b0;
    logic       Up = 1'b1;
    logic [3:0] I = '0;
    logic [3:0] a10, a16;
    logic       c10, c16, z10, z16;

    int n_cmp = 0;
    int n_bad = 0;
    int m10 = 0;
    int m16 = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        bit       clr;
        bit       ld;
        bit       cnt;
        bit       up;
        int       i;
        int       exp_a;
        bit       exp_c;
    } vec_t;
    vec_t vecs[$];

    always #5 CLK = ~CLK;

    updown_mod_counter #(.WIDTH(4), .MODULO(10)) dut10 (
        .CLK(CLK), .Clear(Clear), .Load(Load), .Count(Count), .Up(Up),
        .I(I), .A(a10), .C_out(c10), .Zero(z10)
    );

    updown_mod_counter #(.WIDTH(4), .MODULO(16)) dut16 (
        .CLK(CLK), .Clear(Clear), .Load(Load), .Count(Count), .Up(Up),
        .I(I), .A(a16), .C_out(c16), .Zero(z16)
    );

    function automatic int model_next(int a, int modulo, bit clr, bit ld, bit cnt, bit up, int i);
        int mx;
        mx = modulo - 1;
        if (clr) return 0;
        if (ld) return i;
        if (!cnt) return a;
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
        if (up) return (a >= mx) ? mx : a + 1;
        if (a == 0) return 0;
        return (a - 1 > mx) ? mx : a - 1;
`else
        if (up) return (a > mx) ? 0 : (a + 1) % modulo;
        return (a > mx) ? mx : (a + modulo - 1) % modulo;
`endif
    endfunction

    function automatic bit model_c(int a, int modulo, bit clr, bit ld, bit cnt, bit up);
        return cnt && !ld && !clr && (up ? (a == modulo - 1) : (a == 0));
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic add(input bit clr, input bit ld, input bit cnt, input bit up,
                       input int i, input int exp_a, input bit exp_c);
        vec_t v;
        v.clr = clr; v.ld = ld; v.cnt = cnt; v.up = up;
        v.i = i; v.exp_a = exp_a; v.exp_c = exp_c;
        vecs.push_back(v);
    endtask

    // One clock: drive, check carry before the edge, check state after it.
    task automatic cycle(input bit clr, input bit ld, input bit cnt, input bit up, input int i);
        int n10, n16;
        Clear = clr; Load = ld; Count = cnt; Up = up; I = 4'(i);
        n10 = model_next(m10, 10, clr, ld, cnt, up, i);
        n16 = model_next(m16, 16, clr, ld, cnt, up, i);
        exp_q.push_back(4'(n10));
        #1;
        check("c_out_mod10", int'(c10), int'(model_c(m10, 10, clr, ld, cnt, up)));
        check("c_out_mod16", int'(c16), int'(model_c(m16, 16, clr, ld, cnt, up)));
        @(posedge CLK);
        #1;
        m10 = n10;
        m16 = n16;
        check("a_mod10", int'(a10), int'(exp_q.pop_front()));
        check("a_mod16", int'(a16), m16);
        check("zero_mod10", int'(z10), int'(m10 == 0));
        check("zero_mod16", int'(z16), int'(m16 == 0));
        @(negedge CLK);
    endtask

    initial begin
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
        // Directed vectors target the MODULO=16 instance.
        add(1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 14, 14, 0);
        add(0, 0, 1, 1, 0, 15, 0);
        add(0, 0, 1, 1, 0, 15, 1);
        add(0, 0, 1, 1, 0, 15, 1);
        add(0, 0, 1, 1, 0, 15, 1);
        add(0, 1, 0, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1);
`else
        // Directed vectors target the MODULO=10 instance.
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 5, 5, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 12; k++) add(0, 0, 1, 1, 0, (k + 1) % 10, (k % 10) == 9);
        add(0, 1, 0, 1, 2, 2, 0);
        add(0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 9, 1);
        add(0, 0, 1, 0, 0, 8, 0);
        add(0, 1, 1, 1, 7, 7, 0);
        add(0, 1, 0, 1, 12, 12, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 12, 12, 0);
        add(0, 0, 1, 0, 0, 9, 0);
        add(0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 9, 1);
        add(0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 6, 6, 0);
        add(1, 1, 1, 1, 3, 0, 0);
`endif

        foreach (vecs[n]) begin
            Clear = vecs[n].clr; Load = vecs[n].ld; Count = vecs[n].cnt;
            Up = vecs[n].up; I = 4'(vecs[n].i);
            #1;
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
            check("vec_c_out", int'(c16), int'(vecs[n].exp_c));
            @(posedge CLK);
            #1;
            check("vec_a", int'(a16), vecs[n].exp_a);
            check("vec_zero", int'(z16), int'(vecs[n].exp_a == 0));
`else
            check("vec_c_out", int'(c10), int'(vecs[n].exp_c));
            @(posedge CLK);
            #1;
            check("vec_a", int'(a10), vecs[n].exp_a);
            check("vec_zero", int'(z10), int'(vecs[n].exp_a == 0));
`endif
            @(negedge CLK);
        end

        // Random phase: bring the model into a known state first.
        cycle(1, 0, 0, 1, 0);
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 19) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0,
                  int'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
